gray_rptr_empty: RTL and testbench

Read-side pointer and empty-flag stage of a gray-coded async FIFO. It consumes the gray-coded write pointer produced by the write-domain gray counter and synchronises it into the read clock. It owns the binary and gray read pointers, produces the RAM read address, and produces a registered empty flag and an occupancy count. The gray read pointer it produces goes back to the write domain.

---
 rtl/gray_fifo_pkg.sv | 23 ++
 rtl/gray_rptr_empty_if.sv | 55 +++++
 rtl/gray_bus_sync.sv | 30 +++
 rtl/gray_rptr_empty.sv | 73 +++++++
 tb/tb_gray_rptr_empty.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/gray_fifo_pkg.sv
// Gray/binary conversion helpers shared by both sides of the gray-coded async FIFO.
// Functions work on a MAX_W-bit word; callers zero-extend and truncate to their width.
package gray_fifo_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits decode to zero, so the narrow result is exact.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_rptr_empty_if.sv
// Read-side bundle of the async FIFO: write pointer in, read pointer/flags out.
// GRAY_RPTR_UNDERFLOW_EN adds the sticky underflow flag.
interface gray_rptr_empty_if #(
    parameter int ADDR_W = 4
);

    logic [ADDR_W:0]   wptr_gray_i;
    logic              rd_en;
    logic [ADDR_W:0]   rptr_gray;
    logic [ADDR_W-1:0] raddr;
    logic              empty;
    logic [ADDR_W:0]   rd_count;
`ifdef GRAY_RPTR_UNDERFLOW_EN
    logic              underflow;

    modport master (
        output wptr_gray_i,
        output rd_en,
        input  rptr_gray,
        input  raddr,
        input  empty,
        input  rd_count,
        input  underflow
    );

    modport slave (
        input  wptr_gray_i,
        input  rd_en,
        output rptr_gray,
        output raddr,
        output empty,
        output rd_count,
        output underflow
    );
`else
    modport master (
        output wptr_gray_i,
        output rd_en,
        input  rptr_gray,
        input  raddr,
        input  empty,
        input  rd_count
    );

    modport slave (
        input  wptr_gray_i,
        input  rd_en,
        output rptr_gray,
        output raddr,
        output empty,
        output rd_count
    );
`endif

endinterface

// File: rtl/gray_bus_sync.sv
// Plain multi-flop bus synchroniser for gray-coded pointers crossing clock domains.
// Legal STAGES: 2..4. No logic between stages.
module gray_bus_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/gray_rptr_empty.sv
// Read pointer, RAM read address, registered empty flag and occupancy of the async FIFO.
// Optional GRAY_RPTR_UNDERFLOW_EN: sticky flag for reads attempted while empty.
module gray_rptr_empty
    import gray_fifo_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             srst_n,
    gray_rptr_empty_if.slave bus
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] w_wsync_gray;
    logic [PTR_W-1:0] w_wsync_bin;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;
    logic             w_rd_fire;

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rgray;
    logic             r_empty;

    gray_bus_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wsync (
        .clk    (clk),
        .srst_n (srst_n),
        .d      (bus.wptr_gray_i),
        .q      (w_wsync_gray)
    );

    assign w_wsync_bin  = PTR_W'(gray2bin(MAX_W'(w_wsync_gray)));
    assign w_rd_fire    = bus.rd_en & ~r_empty;
    assign w_rbin_next  = r_rbin + PTR_W'(w_rd_fire);
    assign w_rgray_next = PTR_W'(bin2gray(MAX_W'(w_rbin_next)));

    // Compare against the next pointer so empty never lags a read.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_rbin  <= '0;
            r_rgray <= '0;
            r_empty <= 1'b1;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= (w_rgray_next == w_wsync_gray);
        end
    end

    assign bus.rptr_gray = r_rgray;
    assign bus.raddr     = r_rbin[ADDR_W-1:0];
    assign bus.empty     = r_empty;
    assign bus.rd_count  = w_wsync_bin - r_rbin;

`ifdef GRAY_RPTR_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_underflow <= 1'b0;
        end else if (bus.rd_en && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign bus.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_gray_rptr_empty.sv
// Directed bench for gray_rptr_empty (ADDR_W=4, SYNC_STAGES=2).
module tb_gray_rptr_empty;

    logic clk    = 1'b0;
    logic srst_n = 1'b1;
    int   n_chk  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    gray_rptr_empty_if #(.ADDR_W(4)) bus ();

    gray_rptr_empty #(
        .ADDR_W      (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input int rbin,
                             input int cnt, input logic emp);
        logic [4:0] b;
        b = 5'(rbin);
        check({tag, ".rptr"}, 32'(bus.rptr_gray), 32'(gray(rbin)));
        check({tag, ".raddr"}, 32'(bus.raddr), 32'(b[3:0]));
        check({tag, ".empty"}, 32'(bus.empty), 32'(emp));
        check({tag, ".count"}, 32'(bus.rd_count), 32'(cnt));
    endtask

    initial begin
        bus.wptr_gray_i = '0;
        bus.rd_en       = 1'b0;

        // Reset between edges, observed before any clock edge
        #2 srst_n = 1'b0;
        #1 check_out("rst", 0, 0, 1'b1);
`ifdef GRAY_RPTR_UNDERFLOW_EN
        check("rst.uflow", 32'(bus.underflow), 32'd0);
`endif
        tick(2);
        srst_n = 1'b1;

        // One write: visible on the third edge, then one read
        bus.wptr_gray_i = gray(1);
        tick();
        check("t2.e1.empty", 32'(bus.empty), 32'd1);
        tick();
        check("t2.e2.empty", 32'(bus.empty), 32'd1);
        tick();
        check_out("t2.e3", 0, 1, 1'b0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check_out("t2.rd", 1, 0, 1'b1);

        srst_n = 1'b0;
        bus.wptr_gray_i = '0;
        tick();
        srst_n = 1'b1;

        // Fill to 16, then drain with back-to-back reads
        for (int b = 1; b <= 16; b++) begin
            bus.wptr_gray_i = gray(b);
            tick();
        end
        tick(2);
        check_out("t3.fill", 0, 16, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            check($sformatf("t3.rd%0d.raddr", i), 32'(bus.raddr), 32'(i % 16));
            if (i < 16) begin
                check($sformatf("t3.rd%0d.empty", i), 32'(bus.empty), 32'd0);
            end
        end
        bus.rd_en = 1'b0;
        check_out("t3.drain", 16, 0, 1'b1);

        // Reads while empty are ignored
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("t4.%0d", i), 16, 0, 1'b1);
`ifdef GRAY_RPTR_UNDERFLOW_EN
            check($sformatf("t4.%0d.uflow", i), 32'(bus.underflow), 32'd1);
`endif
        end
        bus.rd_en = 1'b0;
        tick();
`ifdef GRAY_RPTR_UNDERFLOW_EN
        check("t4.sticky", 32'(bus.underflow), 32'd1);
`endif

        // Full pointer wrap: rbin 31 -> 0 -> 1
        for (int b = 17; b <= 31; b++) begin
            bus.wptr_gray_i = gray(b);
            tick();
        end
        tick(2);
        check_out("t5.fill", 16, 15, 1'b0);
        bus.rd_en = 1'b1;
        tick(15);
        bus.rd_en = 1'b0;
        check_out("t5.r31", 31, 0, 1'b1);
        bus.wptr_gray_i = gray(32);
        tick();
        bus.wptr_gray_i = gray(33);
        tick(3);
        check_out("t5.pre", 31, 2, 1'b0);
        bus.rd_en = 1'b1;
        tick();
        check_out("t5.wrap", 0, 1, 1'b0);
        tick();
        bus.rd_en = 1'b0;
        check_out("t5.one", 1, 0, 1'b1);

        // Reset mid-burst
        for (int b = 2; b <= 6; b++) begin
            bus.wptr_gray_i = gray(b);
            tick();
        end
        tick(2);
        check_out("t6.fill", 1, 5, 1'b0);
        bus.rd_en = 1'b1;
        tick();
        check_out("t6.burst", 2, 4, 1'b0);
        #3;
        srst_n = 1'b0;
        bus.wptr_gray_i = '0;
        #1 check_out("t6.rst", 0, 0, 1'b1);
`ifdef GRAY_RPTR_UNDERFLOW_EN
        check("t6.rst.uflow", 32'(bus.underflow), 32'd0);
`endif
        tick(2);
        srst_n = 1'b1;
        tick(4);
        check_out("t6.post", 0, 0, 1'b1);
        bus.rd_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
